// File: rtl/asc_hex_pkg.sv
// ============================================================================
// Module      : asc_hex_pkg
// Description : Shared ASCII constants, character classes and FSM encodings
//               for the ASCII hex word receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package asc_hex_pkg;

  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_9    = 8'h39;
  localparam logic [7:0] ASC_A_UP = 8'h41;
  localparam logic [7:0] ASC_F_UP = 8'h46;
  localparam logic [7:0] ASC_A_LO = 8'h61;
  localparam logic [7:0] ASC_F_LO = 8'h66;
  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_CR   = 8'h0D;

  // Subtracting these from a character in the matching range yields its nibble.
  localparam logic [7:0] OFS_DIGIT = 8'd48;
  localparam logic [7:0] OFS_UPPER = 8'd55;
  localparam logic [7:0] OFS_LOWER = 8'd87;

  typedef enum logic [1:0] {
    CC_HEX     = 2'd0,
    CC_TERM    = 2'd1,
    CC_ILLEGAL = 2'd2
  } char_class_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/asc_hex_char_decode.sv
// ============================================================================
// Module      : asc_hex_char_decode
// Description : Combinational classifier turning an ASCII byte into a
//               character class and a hex nibble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asc_hex_char_decode
  import asc_hex_pkg::*;
#(
  parameter int unsigned CASE_MODE = 0,
  parameter logic [7:0]  DELIM     = ASC_CR
) (
  input  logic [7:0]  din_i,
  output char_class_t class_o,
  output logic [3:0]  nibble_o
);

  logic [7:0] w_offset;
  logic [7:0] w_diff;

  always_comb begin
    class_o  = CC_ILLEGAL;
    w_offset = OFS_DIGIT;
    // Terminators win so a DELIM that happens to look like hex still ends a word.
    if ((din_i == DELIM) || (din_i == ASC_SP)) begin
      class_o = CC_TERM;
    end else if ((din_i >= ASC_0) && (din_i <= ASC_9)) begin
      class_o  = CC_HEX;
      w_offset = OFS_DIGIT;
    end else if ((din_i >= ASC_A_UP) && (din_i <= ASC_F_UP) && (CASE_MODE != 2)) begin
      class_o  = CC_HEX;
      w_offset = OFS_UPPER;
    end else if ((din_i >= ASC_A_LO) && (din_i <= ASC_F_LO) && (CASE_MODE != 1)) begin
      class_o  = CC_HEX;
      w_offset = OFS_LOWER;
    end
  end

  assign w_diff   = din_i - w_offset;
  assign nibble_o = w_diff[3:0];

endmodule

`default_nettype wire

// File: rtl/ascii_hex_word_rx.sv
// ============================================================================
// Module      : ascii_hex_word_rx
// Description : Assembles ASCII hex characters into a DIGITS-nibble word and
//               emits it with digit count and error flag over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_hex_word_rx
  import asc_hex_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned CASE_MODE = 0,
  parameter logic [7:0]  DELIM     = ASC_CR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   din,
  input  logic                         din_vld,
  output logic                         din_rdy,
  output logic [4*DIGITS-1:0]          dout,
  output logic [$clog2(DIGITS+1)-1:0]  dout_cnt,
  output logic                         dout_err,
  output logic                         dout_vld,
  input  logic                         dout_rdy
);

  localparam int unsigned   W        = 4 * DIGITS;
  localparam int unsigned   CW       = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] C_DIGITS = CW'(DIGITS);

  char_class_t   w_class;
  logic [3:0]    w_nib;
  logic          w_take;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [CW-1:0] dout_cnt_q, dout_cnt_d;
  logic          dout_err_q, dout_err_d;
  logic          dout_vld_q, dout_vld_d;

  asc_hex_char_decode #(
    .CASE_MODE (CASE_MODE),
    .DELIM     (DELIM)
  ) u_decode (
    .din_i    (din),
    .class_o  (w_class),
    .nibble_o (w_nib)
  );

  assign w_take = din_vld && din_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_take && (w_class != CC_TERM)) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_take && (w_class == CC_TERM)) begin
          state_d = ((cnt_q == '0) && !err_q) ? ST_IDLE : ST_OUT;
        end
      end
      ST_OUT: begin
        if (dout_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    din_rdy = (state_q != ST_OUT);
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    dout_d     = dout_q;
    dout_cnt_d = dout_cnt_q;
    dout_err_d = dout_err_q;
    dout_vld_d = dout_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (w_take && (w_class == CC_HEX)) begin
          acc_d = W'(w_nib);
          cnt_d = CW'(1);
        end else if (w_take && (w_class == CC_ILLEGAL)) begin
          acc_d = '0;
          cnt_d = '0;
          err_d = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (w_take) begin
          case (w_class)
            CC_HEX: begin
              // Count is checked before shifting so no accepted digit is lost.
              if (cnt_q < C_DIGITS) begin
                acc_d = (acc_q << 4) | W'(w_nib);
                cnt_d = cnt_q + CW'(1);
              end else begin
                err_d = 1'b1;
              end
            end
            CC_ILLEGAL: err_d = 1'b1;
            default: begin
              if ((cnt_q != '0) || err_q) begin
                dout_d     = acc_q;
                dout_cnt_d = cnt_q;
                dout_err_d = err_q;
                dout_vld_d = 1'b1;
              end
            end
          endcase
        end
      end
      ST_OUT: begin
        if (dout_rdy) begin
          dout_vld_d = 1'b0;
          acc_d      = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      dout_q     <= '0;
      dout_cnt_q <= '0;
      dout_err_q <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
      dout_cnt_q <= dout_cnt_d;
      dout_err_q <= dout_err_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dout     = dout_q;
  assign dout_cnt = dout_cnt_q;
  assign dout_err = dout_err_q;
  assign dout_vld = dout_vld_q;

endmodule

`default_nettype wire
